// File: rtl/key_debounce_pkg.sv
// -----------------------------------------------------------------------------
// key_debounce_pkg
//   Shared definitions for the push-button input path.
//   - key_state_e : debounce FSM states
//   - CLK_HZ      : system clock frequency of the PLL domain
//   - cnt_width() : counter width helper. It never returns 0, so a counter
//                   whose range is degenerate still gets a legal vector.
// -----------------------------------------------------------------------------
package key_debounce_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } key_state_e;

    localparam int unsigned CLK_HZ = 40_000_000;

    // Bits needed to hold the values 0..n-1 (at least 1).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/key_debounce_tick_gen.sv
// -----------------------------------------------------------------------------
// tick_gen
//   Free-running prescaler. It counts 0..DIV-1 and raises tick for exactly one
//   clk while the count is DIV-1, then wraps to 0. Transitions elsewhere never
//   clear it, so all users share one fixed tick grid.
// Ports
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset (count returns to 0)
//   tick   out  one-cycle strobe every DIV clk
// -----------------------------------------------------------------------------
module tick_gen #(
    parameter int unsigned DIV = 4000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);
    import key_debounce_pkg::*;

    localparam int unsigned W    = cnt_width(DIV);
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        tick  = (cnt_q == LAST);
        cnt_d = tick ? '0 : cnt_q + W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
//   Reads one mechanical push-button and delivers clean clk-synchronous events.
//   The raw pin is synchronised by two flops, folded to "pressed" polarity and
//   debounced on a tick grid from tick_gen. A change is only accepted after
//   DEBOUNCE_TICKS consecutive ticks of the new level.
// Ports
//   clk          in   system clock (PLL 40 MHz)
//   rst_n        in   asynchronous active-low reset
//   key_in       in   raw button pin, asynchronous to clk
//   key_level    out  debounced level, 1 = pressed
//   key_press    out  1-cycle pulse on accepted press
//   key_release  out  1-cycle pulse on accepted release
//   key_long     out  1-cycle pulse, once per press, after LONG_TICKS in HELD
// -----------------------------------------------------------------------------
module key_debounce #(
    parameter int unsigned TICK_DIV       = 4000,
    parameter int unsigned DEBOUNCE_TICKS = 200,
    parameter int unsigned LONG_TICKS     = 10000,
    parameter bit          KEY_ACTIVE_LOW = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_in,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic key_long
);
    import key_debounce_pkg::*;

    localparam int unsigned DEB_W  = cnt_width(DEBOUNCE_TICKS + 1);
    localparam int unsigned LONG_W = cnt_width(LONG_TICKS + 1);

    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_TICKS - 1);
    localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_TICKS - 1);
    localparam logic [LONG_W-1:0] LONG_MAX  = LONG_W'(LONG_TICKS);

    // Pin level of a released key; the synchroniser resets to it so that
    // reset release does not look like an edge.
    localparam logic RELEASED_LVL = KEY_ACTIVE_LOW;

    // ------------------------------------------------------------------
    // Input path
    // ------------------------------------------------------------------
    logic sync1_q;
    logic sync2_q;
    logic pressed;
    logic tick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= RELEASED_LVL;
            sync2_q <= RELEASED_LVL;
        end else begin
            sync1_q <= key_in;
            sync2_q <= sync1_q;
        end
    end

    assign pressed = sync2_q ^ KEY_ACTIVE_LOW;

    tick_gen #(
        .DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    // ------------------------------------------------------------------
    // Debounce FSM
    // ------------------------------------------------------------------
    key_state_e        state_q,    state_d;
    logic [DEB_W-1:0]  deb_cnt_q,  deb_cnt_d;
    logic [LONG_W-1:0] long_cnt_q, long_cnt_d;
    logic              level_q,    level_d;
    logic              press_q,    press_d;
    logic              release_q,  release_d;
    logic              long_q,     long_d;

    always_comb begin
        state_d    = state_q;
        deb_cnt_d  = deb_cnt_q;
        long_cnt_d = long_cnt_q;
        press_d    = 1'b0;
        release_d  = 1'b0;
        long_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (pressed) begin
                    state_d   = PRESS_WAIT;
                    deb_cnt_d = '0;
                end
            end

            PRESS_WAIT: begin
                if (!pressed) begin
                    state_d = IDLE;
                end else if (tick) begin
                    deb_cnt_d = deb_cnt_q + DEB_W'(1);
                    if (deb_cnt_q == DEB_LAST) begin
                        state_d    = HELD;
                        press_d    = 1'b1;
                        long_cnt_d = '0;
                    end
                end
            end

            HELD: begin
                if (!pressed) begin
                    state_d   = RELEASE_WAIT;
                    deb_cnt_d = '0;
                end else if (tick && (long_cnt_q != LONG_MAX)) begin
                    // Saturation makes the pulse fire once per press.
                    long_cnt_d = long_cnt_q + LONG_W'(1);
                    long_d     = (long_cnt_q == LONG_LAST);
                end
            end

            RELEASE_WAIT: begin
                if (pressed) begin
                    // long_cnt is left alone: a release bounce must not
                    // restart the long-press timer.
                    state_d = HELD;
                end else if (tick) begin
                    deb_cnt_d = deb_cnt_q + DEB_W'(1);
                    if (deb_cnt_q == DEB_LAST) begin
                        state_d   = IDLE;
                        release_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Registered from the next state so the level flips on the same
        // clk as the press/release pulse.
        level_d = (state_d == HELD) || (state_d == RELEASE_WAIT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            deb_cnt_q  <= '0;
            long_cnt_q <= '0;
            level_q    <= 1'b0;
            press_q    <= 1'b0;
            release_q  <= 1'b0;
            long_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            deb_cnt_q  <= deb_cnt_d;
            long_cnt_q <= long_cnt_d;
            level_q    <= level_d;
            press_q    <= press_d;
            release_q  <= release_d;
            long_q     <= long_d;
        end
    end

    assign key_level   = level_q;
    assign key_press   = press_q;
    assign key_release = release_q;
    assign key_long    = long_q;

endmodule

// File: tb/tb_key_debounce.sv
// -----------------------------------------------------------------------------
// tb_key_debounce
//   Segment table of {reset, pin level, length, expected pulse counts, final
//   level}, a few hand-written corner sequences, then randomized pin activity.
//   Every clk the outputs are also compared with a behavioural model: the
//   accepted level flips once the pin has disagreed with it for DEB ticks in
//   a row, and long-press ticks accumulate only while the pin agrees with an
//   accepted press.
// -----------------------------------------------------------------------------
module tb_key_debounce;

    localparam int TD = 4;   // TICK_DIV
    localparam int DT = 3;   // DEBOUNCE_TICKS
    localparam int LT = 8;   // LONG_TICKS

    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic key_in = 1'b1;
    logic key_level, key_press, key_release, key_long;

    always #5 clk = ~clk;

    key_debounce #(
        .TICK_DIV       (TD),
        .DEBOUNCE_TICKS (DT),
        .LONG_TICKS     (LT),
        .KEY_ACTIVE_LOW (1'b1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_in      (key_in),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release),
        .key_long    (key_long)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- reference model ----------------
    int m_cyc;          // clk edges since reset release
    bit m_k1, m_k2;     // pin samples one and two edges ago
    bit m_acc;          // accepted (debounced) pressed level
    bit m_run;          // pin currently disagrees with m_acc
    int m_run_ticks;    // ticks counted during the current disagreement
    int m_long_ticks;   // ticks spent holding the current press
    bit e_lvl, e_pr, e_rl, e_lg;

    // ---------------- per-segment bookkeeping ----------------
    int seg_idx, seg_press, seg_rel, seg_long, press_at, long_at;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_cmp++;
        if (act < lo || act > hi) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d..%0d (t=%0t)", name, act, lo, hi, $time);
        end
    endtask

    task automatic m_reset();
        m_cyc = 0; m_k1 = 1'b1; m_k2 = 1'b1;
        m_acc = 1'b0; m_run = 1'b0; m_run_ticks = 0; m_long_ticks = 0;
        e_lvl = 1'b0; e_pr = 1'b0; e_rl = 1'b0; e_lg = 1'b0;
    endtask

    task automatic m_edge();
        bit p, t;
        if (!rst_n) return;
        m_cyc++;
        t  = (m_cyc % TD) == 0;
        p  = ~m_k2;              // active-low pin seen after two clk
        m_k2 = m_k1;
        m_k1 = key_in;
        e_pr = 1'b0; e_rl = 1'b0; e_lg = 1'b0;
        if (p != m_acc) begin
            if (!m_run) begin
                m_run = 1'b1;
                m_run_ticks = 0;
            end else if (t) begin
                m_run_ticks++;
                if (m_run_ticks == DT) begin
                    m_acc = p;
                    m_run = 1'b0;
                    if (p) begin e_pr = 1'b1; m_long_ticks = 0; end
                    else e_rl = 1'b1;
                end
            end
        end else if (m_run) begin
            m_run = 1'b0;
        end else if (m_acc && t && m_long_ticks < LT) begin
            m_long_ticks++;
            e_lg = (m_long_ticks == LT);
        end
        e_lvl = m_acc;
    endtask

    task automatic begin_seg();
        seg_idx = 0; seg_press = 0; seg_rel = 0; seg_long = 0;
        press_at = -1; long_at = -1;
    endtask

    // One clk: drive at negedge, compare #1 after posedge.
    task automatic cyc(input bit k, input bit r);
        @(negedge clk);
        key_in = k;
        rst_n  = r;
        if (!r) begin
            m_reset();
            #1;
            check("reset_outputs_zero",
                  {28'd0, key_level, key_press, key_release, key_long}, 32'd0);
        end
        @(posedge clk);
        m_edge();
        #1;
        check("key_level",   key_level,   e_lvl);
        check("key_press",   key_press,   e_pr);
        check("key_release", key_release, e_rl);
        check("key_long",    key_long,    e_lg);
        check("single_pulse",
              (32'(key_press) + 32'(key_release) + 32'(key_long)) <= 32'd1, 32'd1);
        if (key_press === 1'b1) begin
            seg_press++;
            if (press_at < 0) press_at = seg_idx;
        end
        if (key_release === 1'b1) seg_rel++;
        if (key_long === 1'b1) begin
            seg_long++;
            if (long_at < 0) long_at = seg_idx;
        end
        seg_idx++;
    endtask

    typedef struct {
        bit rst_n;
        bit key;
        int len;
        int n_press;
        int n_rel;
        int n_long;
        bit lvl;
        int chk;        // 0: none, 1: press latency window, 2: long delay
    } seg_t;

    localparam int NSEG = 16;
    seg_t segs [NSEG];

    bit rk;
    int rlen;

    initial begin
        segs = '{
            '{1'b0, 1'b1,   3, 0, 0, 0, 1'b0, 0},  // reset, released pin
            '{1'b1, 1'b1, 100, 0, 0, 0, 1'b0, 0},  // quiet after reset
            '{1'b1, 1'b0,  40, 1, 0, 0, 1'b1, 1},  // clean press
            '{1'b1, 1'b1,  30, 0, 1, 0, 1'b0, 0},  // clean release
            '{1'b1, 1'b0,   5, 0, 0, 0, 1'b0, 0},  // press bounce
            '{1'b1, 1'b1,   3, 0, 0, 0, 1'b0, 0},
            '{1'b1, 1'b0,   6, 0, 0, 0, 1'b0, 0},
            '{1'b1, 1'b1,  20, 0, 0, 0, 1'b0, 0},
            '{1'b1, 1'b0,  60, 1, 0, 1, 1'b1, 2},  // long press
            '{1'b1, 1'b1,   2, 0, 0, 0, 1'b1, 0},  // release bounce
            '{1'b1, 1'b0,   1, 0, 0, 0, 1'b1, 0},
            '{1'b1, 1'b1,  30, 0, 1, 0, 1'b0, 0},
            '{1'b1, 1'b0,  30, 1, 0, 0, 1'b1, 0},  // press, then reset in HELD
            '{1'b0, 1'b0,   3, 0, 0, 0, 1'b0, 0},
            '{1'b1, 1'b0,  36, 1, 0, 0, 1'b1, 1},  // held key seen as new press
            '{1'b1, 1'b1,  30, 0, 1, 0, 1'b0, 0}
        };

        m_reset();

        for (int s = 0; s < NSEG; s++) begin
            begin_seg();
            for (int c = 0; c < segs[s].len; c++) cyc(segs[s].key, segs[s].rst_n);
            check($sformatf("seg%0d_press_count", s),   seg_press, segs[s].n_press);
            check($sformatf("seg%0d_release_count", s), seg_rel,   segs[s].n_rel);
            check($sformatf("seg%0d_long_count", s),    seg_long,  segs[s].n_long);
            check($sformatf("seg%0d_level", s),         key_level, segs[s].lvl);
            if (segs[s].chk == 1)
                check_range($sformatf("seg%0d_press_latency", s), press_at, 11, 14);
            if (segs[s].chk == 2)
                check($sformatf("seg%0d_long_after_press", s), long_at - press_at, 32);
        end

        // Pin toggling every clk: stays in the wait states, no events.
        begin_seg();
        for (int c = 0; c < 40; c++) cyc(c[0], 1'b1);
        for (int c = 0; c < 10; c++) cyc(1'b1, 1'b1);
        check("toggle_no_press", seg_press, 0);
        check("toggle_no_release", seg_rel, 0);
        check("toggle_level", key_level, 1'b0);

        // Release bounces part-way through the long timer: the long pulse
        // still fires exactly once for this press.
        begin_seg();
        for (int c = 0; c < 30; c++) cyc(1'b0, 1'b1);
        for (int c = 0; c < 2;  c++) cyc(1'b1, 1'b1);
        for (int c = 0; c < 40; c++) cyc(1'b0, 1'b1);
        for (int c = 0; c < 30; c++) cyc(1'b1, 1'b1);
        check("bounced_long_once", seg_long, 1);
        check("bounced_release_once", seg_rel, 1);

        // Randomized pin activity with occasional resets.
        for (int i = 0; i < 150; i++) begin
            rk = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) rlen = $urandom_range(1, 3);
            else rlen = $urandom_range(4, 80);
            if ($urandom_range(0, 39) == 0) begin
                for (int j = 0; j < 2; j++) cyc(rk, 1'b0);
            end
            for (int j = 0; j < rlen; j++) cyc(rk, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
